// File: rtl/ex_operand_stage.sv
// ex_operand_stage: operand capture/forwarding stage with 2-entry skid buffer feeding the ALU.
// Define FWD_EN to resolve rs/rt against the EX/MEM and MEM/WB forwarding paths.
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int OP_W   = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_aluop,
  input  logic [IDX_W-1:0]  in_rs_idx,
  input  logic [IDX_W-1:0]  in_rt_idx,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [15:0]       in_imm16,
  input  logic [4:0]        in_shamt,
  input  logic [1:0]        in_bsel,
  input  logic              fwd_exmem_wen,
  input  logic [IDX_W-1:0]  fwd_exmem_idx,
  input  logic [DATA_W-1:0] fwd_exmem_data,
  input  logic              fwd_memwb_wen,
  input  logic [IDX_W-1:0]  fwd_memwb_idx,
  input  logic [DATA_W-1:0] fwd_memwb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_aluop,
  output logic [DATA_W-1:0] out_portA,
  output logic [DATA_W-1:0] out_portB
);
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } ent_t;
  logic              or_vld_q, or_vld_d, sr_vld_q, sr_vld_d;
  ent_t              or_q, or_d, sr_q, sr_d, new_e;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic              accept;
`ifdef FWD_EN
  // Register 0 is hardwired, so it never takes a forwarded value.
  assign rs_fwd = in_rs_idx == '0 ? in_rs_val :
                  (fwd_exmem_wen && fwd_exmem_idx == in_rs_idx) ? fwd_exmem_data :
                  (fwd_memwb_wen && fwd_memwb_idx == in_rs_idx) ? fwd_memwb_data : in_rs_val;
  assign rt_fwd = in_rt_idx == '0 ? in_rt_val :
                  (fwd_exmem_wen && fwd_exmem_idx == in_rt_idx) ? fwd_exmem_data :
                  (fwd_memwb_wen && fwd_memwb_idx == in_rt_idx) ? fwd_memwb_data : in_rt_val;
`else
  logic unused_fwd;
  assign unused_fwd = ^{in_rs_idx, in_rt_idx, fwd_exmem_wen, fwd_exmem_idx, fwd_exmem_data,
                        fwd_memwb_wen, fwd_memwb_idx, fwd_memwb_data};
  assign rs_fwd = in_rs_val;
  assign rt_fwd = in_rt_val;
`endif
  // Shifts move rt into portA so the ALU can shift portA by portB.
  always_comb begin
    new_e.op = in_aluop;
    new_e.a  = in_bsel == 2'b11 ? rt_fwd : rs_fwd;
    new_e.b  = in_bsel == 2'b00 ? rt_fwd :
               in_bsel == 2'b01 ? {{(DATA_W-16){in_imm16[15]}}, in_imm16} :
               in_bsel == 2'b10 ? {{(DATA_W-16){1'b0}}, in_imm16} :
                                  {{(DATA_W-5){1'b0}}, in_shamt};
  end
  assign in_ready = !sr_vld_q;
  assign accept   = in_valid && in_ready;
  always_comb begin
    or_vld_d = or_vld_q;
    sr_vld_d = sr_vld_q;
    or_d     = or_q;
    sr_d     = sr_q;
    if (flush) begin
      or_vld_d = 1'b0;
      sr_vld_d = 1'b0;
    end else if (!or_vld_q || out_ready) begin
      or_vld_d = sr_vld_q || accept;
      or_d     = sr_vld_q ? sr_q : accept ? new_e : or_q;
      sr_vld_d = 1'b0;
    end else if (accept) begin
      sr_vld_d = 1'b1;
      sr_d     = new_e;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      or_vld_q <= 1'b0;
      sr_vld_q <= 1'b0;
      or_q     <= '0;
      sr_q     <= '0;
    end else begin
      or_vld_q <= or_vld_d;
      sr_vld_q <= sr_vld_d;
      or_q     <= or_d;
      sr_q     <= sr_d;
    end
  end
  assign out_valid = or_vld_q;
  assign out_aluop = or_q.op;
  assign out_portA = or_q.a;
  assign out_portB = or_q.b;
endmodule
